// File: rtl/ruta_datos.sv
// Bus-oriented datapath: registers A, B, C, T and AC share one internal bus,
// with a T +/- bus ALU feeding AC and a result register captured at fin.
module ruta_datos #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Wa,
  input  logic         Wb,
  input  logic         Wc,
  input  logic         Wt,
  input  logic         Wac,
  input  logic         Ra,
  input  logic         Rb,
  input  logic         Rc,
  input  logic         Rac,
  input  logic         S,
  input  logic         R,
  input  logic         fin,
  input  logic         load,
  input  logic [N-1:0] din_a,
  input  logic [N-1:0] din_b,
  output logic [N-1:0] bus,
  output logic [N-1:0] result,
  output logic         result_valid,
  output logic         cy,
  output logic         bus_err
);

  logic [N-1:0] reg_a, reg_b, reg_c, reg_t, reg_ac;
  logic [2:0]   rd_count;
  logic         rd_conflict;
  logic         op_conflict;
  logic [N:0]   sum;
  logic [N:0]   diff;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_count    = 3'(Ra) + 3'(Rb) + 3'(Rc) + 3'(Rac);
    rd_conflict = (rd_count > 3'd1);
    op_conflict = S & R;
    bus         = '0;
    if (!rd_conflict) begin
      if (Ra)       bus = reg_a;
      else if (Rb)  bus = reg_b;
      else if (Rc)  bus = reg_c;
      else if (Rac) bus = reg_ac;
    end
  end

  // Extra top bit holds the carry of the add and the borrow of the subtract.
  assign sum  = {1'b0, reg_t} + {1'b0, bus};
  assign diff = {1'b0, reg_t} - {1'b0, bus};

  // NOTE: state is updated with non-blocking assignments so every register
  // sees the pre-edge bus and register values, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_a        <= '0;
      reg_b        <= '0;
      reg_c        <= '0;
      reg_t        <= '0;
      reg_ac       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      cy           <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      // A read conflict suppresses every register write, operand load included.
      if (!rd_conflict) begin
        if (load)    reg_a <= din_a;
        else if (Wa) reg_a <= bus;
        if (load)    reg_b <= din_b;
        else if (Wb) reg_b <= bus;
        if (Wc)      reg_c <= bus;
        if (Wt)      reg_t <= bus;
        if (Wac && !op_conflict) begin
          if (S) begin
            reg_ac <= sum[N-1:0];
            cy     <= sum[N];
          end else if (R) begin
            reg_ac <= diff[N-1:0];
            cy     <= diff[N];
          end else begin
            reg_ac <= bus;
          end
        end
      end

      if (rd_conflict || op_conflict) bus_err <= 1'b1;

      result_valid <= fin;
      if (fin) result <= reg_c;
    end
  end

endmodule

// File: tb/tb_ruta_datos.sv
// Directed bench for ruta_datos: stimulus pushes expected results into a
// scoreboard queue that a monitor drains on every result_valid pulse.
module tb_ruta_datos;

  localparam int N = 8;

  localparam logic [3:0] RA  = 4'b1000, RB = 4'b0100, RC = 4'b0010, RAC = 4'b0001;
  localparam logic [4:0] WA  = 5'b10000, WC = 5'b00100, WT = 5'b00010, WAC = 5'b00001;
  localparam logic [1:0] ADD = 2'b10, SUB = 2'b01, PASS = 2'b00, BOTH = 2'b11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Wa, Wb, Wc, Wt, Wac, Ra, Rb, Rc, Rac, S, R, fin, load;
  logic [N-1:0] din_a, din_b;
  logic [N-1:0] bus, result;
  logic         result_valid, cy, bus_err;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [N-1:0] exp_q[$];

  ruta_datos #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .Wa(Wa), .Wb(Wb), .Wc(Wc), .Wt(Wt), .Wac(Wac),
    .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rac(Rac),
    .S(S), .R(R), .fin(fin), .load(load),
    .din_a(din_a), .din_b(din_b),
    .bus(bus), .result(result), .result_valid(result_valid),
    .cy(cy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Controls change on the falling edge and are captured by the next rising edge.
  task automatic ctl(input logic [3:0] rd, input logic [4:0] wr,
                     input logic [1:0] sr = PASS, input logic f = 1'b0,
                     input logic ld = 1'b0, input logic [N-1:0] da = '0,
                     input logic [N-1:0] db = '0);
    @(negedge clk);
    {Ra, Rb, Rc, Rac}     = rd;
    {Wa, Wb, Wc, Wt, Wac} = wr;
    {S, R}                = sr;
    fin                   = f;
    load                  = ld;
    din_a                 = da;
    din_b                 = db;
  endtask

  task automatic idle();
    ctl(4'b0, 5'b0);
    #1;
  endtask

  task automatic peek(input logic [3:0] rd, input logic [N-1:0] exp, input string name);
    ctl(rd, 5'b0);
    #1 check(name, bus, exp);
  endtask

  task automatic load_ops(input logic [N-1:0] a, input logic [N-1:0] b);
    ctl(4'b0, 5'b0, PASS, 1'b0, 1'b1, a, b);
  endtask

  // Program from the operand-load sequence: 3 and 5 end up as result 16.
  task automatic run_program();
    load_ops(8'd3, 8'd5);
    ctl(RA, WT);
    ctl(RA, WAC, ADD);
    ctl(RAC, WC);
    ctl(RB, WT);
    ctl(RB, WAC, ADD);
    ctl(RAC, WA);
    ctl(RC, WT);
    ctl(RC, WT);
    ctl(RA, WAC, ADD);
    ctl(RAC, WC);
    ctl(4'b0, 5'b0, PASS, 1'b1);
    exp_q.push_back(8'd16);
    idle();
    check("program_cy", cy, 1'b0);
    peek(RC, 8'd16, "program_c");
  endtask

  // Monitor: every result_valid pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (exp_q.size() == 0) check("unexpected_result_valid", result_valid, 1'b0);
        else check("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    {Ra, Rb, Rc, Rac, Wa, Wb, Wc, Wt, Wac, S, R, fin, load} = '0;
    din_a = '0;
    din_b = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 8'd0);
    check("reset_valid", result_valid, 1'b0);
    check("reset_cy", cy, 1'b0);
    check("reset_bus_err", bus_err, 1'b0);
    reset = 1'b0;
    peek(RA, 8'd0, "reset_a");
    peek(RAC, 8'd0, "reset_ac");

    run_program();

    // Subtract with borrow: 5 - 7 = 0xFE.
    load_ops(8'd5, 8'h00);
    ctl(RA, WT);
    load_ops(8'd7, 8'h99);
    ctl(RA, WAC, SUB);
    idle();
    check("sub_borrow_cy", cy, 1'b1);
    peek(RAC, 8'hFE, "sub_ac");

    // Plain transfer into AC leaves cy alone.
    ctl(RB, WAC, PASS);
    idle();
    check("pass_cy_kept", cy, 1'b1);
    peek(RAC, 8'h99, "pass_ac");

    ctl(RA, WAC, ADD);
    idle();
    check("add_nocarry_cy", cy, 1'b0);
    peek(RAC, 8'h0C, "add_ac");

    // Read and write AC in one cycle: bus shows the old value.
    ctl(RAC, WAC, ADD);
    #1 check("rmw_bus_old", bus, 8'h0C);
    peek(RAC, 8'h11, "rmw_ac_new");

    // Add with carry: 0xF0 + 0x20 = 0x10, cy = 1.
    load_ops(8'hF0, 8'h00);
    ctl(RA, WT);
    load_ops(8'h20, 8'h00);
    ctl(RA, WAC, ADD);
    idle();
    check("add_carry_cy", cy, 1'b1);
    peek(RAC, 8'h10, "add_carry_ac");

    // Read conflict.
    check("bus_err_clear", bus_err, 1'b0);
    load_ops(8'h11, 8'h22);
    ctl(RA, WC);
    ctl(RA | RB, WC);
    #1 check("conflict_bus", bus, 8'h00);
    idle();
    check("conflict_bus_err", bus_err, 1'b1);
    peek(RC, 8'h11, "conflict_c_kept");
    repeat (10) idle();
    check("bus_err_sticky", bus_err, 1'b1);

    // S and R together: AC and cy stay put.
    ctl(RB, WAC, BOTH);
    idle();
    check("sr_conflict_cy", cy, 1'b1);
    peek(RAC, 8'h10, "sr_conflict_ac");

    // load overrides Wa.
    load_ops(8'h33, 8'h00);
    ctl(RA, WC);
    ctl(RC, WA, PASS, 1'b0, 1'b1, 8'h44, 8'h55);
    peek(RA, 8'h44, "load_over_wa");
    peek(RB, 8'h55, "load_b");

    // fin held two cycles; first capture sees C before its same-cycle write.
    ctl(RA, WC, PASS, 1'b1);
    exp_q.push_back(8'h33);
    ctl(4'b0, 5'b0, PASS, 1'b1);
    exp_q.push_back(8'h44);
    idle();
    idle();

    // Reset mid-program, while T<-B is on the control lines.
    load_ops(8'd3, 8'd5);
    ctl(RA, WT);
    ctl(RA, WAC, ADD);
    ctl(RAC, WC);
    ctl(RB, WT);
    #2 reset = 1'b1;
    #1;
    check("midreset_result", result, 8'd0);
    check("midreset_valid", result_valid, 1'b0);
    check("midreset_cy", cy, 1'b0);
    check("midreset_bus_err", bus_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    peek(RA, 8'd0, "midreset_a");
    peek(RC, 8'd0, "midreset_c");

    run_program();

    repeat (3) idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ruta_datos.md
RUTA_DATOS -- requirements
Module: ruta_datos

Interface
REQ-001 SHALL have parameter N, default 8, giving the data width of all registers and the bus.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports Wa, Wb, Wc, Wt, Wac, input, 1 each, register write enables driven by the control unit.
REQ-005 SHALL have ports Ra, Rb, Rc, Rac, input, 1 each, bus source selects.
REQ-006 SHALL have ports S and R, input, 1 each, ALU add and subtract selects.
REQ-007 SHALL have port fin, input, 1, end-of-operation strobe from the control unit.
REQ-008 SHALL have ports load, input, 1, and din_a and din_b, input, N each, for the external operand load of A and B.
REQ-009 SHALL have port bus, output, N, current internal bus value.
REQ-010 SHALL have port result, output, N, registered copy of C captured at fin.
REQ-011 SHALL have port result_valid, output, 1, one-cycle pulse when result updates.
REQ-012 SHALL have port cy, output, 1, carry/borrow flag from the last ALU operation.
REQ-013 SHALL have port bus_err, output, 1, sticky error flag for illegal control combinations.

Function
REQ-014 SHALL hold internal registers A, B, C, T and AC, each N bits wide.
REQ-015 SHALL drive the bus combinationally from A, B, C or AC when exactly one of Ra, Rb, Rc or Rac is high, respectively.
REQ-016 SHALL drive the bus to 0 when no read select is high.
REQ-017 SHALL treat two or more read selects high in one cycle as a conflict: bus = 0, no register writes that cycle, bus_err set.
REQ-018 SHALL, on a clock edge without conflict, load the bus into each of A, B, C and T whose write enable is high; multiple simultaneous writes are legal.
REQ-019 SHALL set AC <= (T + bus) mod 2^N and cy <= the carry out when Wac = 1, S = 1 and R = 0.
REQ-020 SHALL set AC <= (T - bus) mod 2^N and cy <= borrow (1 when T < bus, unsigned) when Wac = 1, R = 1 and S = 0.
REQ-021 SHALL set AC <= bus with cy unchanged when Wac = 1 and S = R = 0.
REQ-022 SHALL treat S = R = 1 as a conflict: no AC or cy update, bus_err set; other writes that cycle proceed.
REQ-023 SHALL not update AC or cy when Wac = 0, regardless of S and R.
REQ-024 SHALL, when load = 1, set A <= din_a and B <= din_b; load overrides Wa and Wb in the same cycle, and other writes proceed normally.
REQ-025 SHALL, on a clock edge with fin = 1, set result <= C (the pre-edge value) and pulse result_valid high for exactly that following cycle.
REQ-026 SHALL, when fin is held high for k cycles, capture C on every such edge and keep result_valid high for k cycles.
REQ-027 SHALL keep bus_err set once it is set, until reset.
REQ-028 SHALL read the pre-edge value when a register is read and written in the same cycle (for example Rac with Wac), with the new value visible next cycle.

Reset
REQ-029 SHALL, on reset, asynchronously clear A, B, C, T, AC, result, cy, result_valid and bus_err to 0.
REQ-030 SHALL abort any operation when reset is asserted mid-sequence, with no partial write on the reset edge; after reset deassertion the first rising edge with load = 1 reloads the operands.

Verification
REQ-031 SHALL pass: load with din_a = 3 and din_b = 5, then the sequence T<-A, AC<-T+A, C<-AC, T<-B, AC<-T+B, A<-AC, T<-C, T<-C, AC<-T+A, C<-AC, fin -> result = 16, result_valid pulses 1 cycle, cy = 0.
REQ-032 SHALL pass: N = 8, T = 0xF0, bus = A = 0x20, Wac and S -> AC = 0x10, cy = 1.
REQ-033 SHALL pass: T = 0x05, A = 0x07, Wac and R with Ra -> AC = 0xFE, cy = 1.
REQ-034 SHALL pass: Ra and Rb high together with Wc -> bus = 0, C unchanged, bus_err = 1 and still 1 after 10 idle cycles.
REQ-035 SHALL pass: load = 1 and Wa = 1 with Rc, C = 0x33, din_a = 0x44 -> A = 0x44.
REQ-036 SHALL pass: reset asserted between C<-AC and T<-B -> all outputs 0 immediately, and a reload-and-rerun gives result = 16.
